// File: rtl/frame_capture.sv
// Triggered frame recorder: keeps a circular sample history, detects a level crossing with
// hysteresis (or times out), then freezes a DEPTH-sample frame for the display to read.
module frame_capture #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int PRE_TRIG     = 64,
    parameter int HYST         = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              arm,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic              trig_auto,
    output logic [2:0]        state_o
);

    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST_FILL = 3'd3,
        HOLD      = 3'd4
    } state_t;

    // Handshake: frame_ready rises the cycle after the last post-trigger write and stays high
    // until frame_ack is seen while it is high; frame_ack at any other time has no effect.

    state_t             state, state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  start_ptr;
    logic [ADDR_W-1:0]  pre_cnt;
    logic [ADDR_W-1:0]  post_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               hyst_flag;
    logic [ADDR_W-1:0]  rd_ptr;

    logic               wr_en;
    logic               clear_cnt;
    logic               flag_set;
    logic               level_hit;
    logic               auto_hit;
    logic               trig_take;
    logic               done;
    logic               frame_release;

    // Hysteresis thresholds, computed one bit wider and clamped to the sample range.
    logic [DATA_W:0]    lo_full, hi_full;
    logic [DATA_W-1:0]  thr_lo, thr_hi;

    assign lo_full = {1'b0, trig_level} - (DATA_W+1)'(HYST);
    assign hi_full = {1'b0, trig_level} + (DATA_W+1)'(HYST);
    assign thr_lo  = lo_full[DATA_W] ? '0 : lo_full[DATA_W-1:0];
    assign thr_hi  = hi_full[DATA_W] ? '1 : hi_full[DATA_W-1:0];

    assign rd_ptr  = start_ptr + rd_addr;
    assign state_o = state;

    always_comb begin
        state_next    = state;
        wr_en         = 1'b0;
        clear_cnt     = 1'b0;
        flag_set      = 1'b0;
        level_hit     = 1'b0;
        auto_hit      = 1'b0;
        trig_take     = 1'b0;
        done          = 1'b0;
        frame_release = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = PRE_FILL;
                    clear_cnt  = 1'b1;
                end
            end
            PRE_FILL: begin
                if (!arm) begin
                    state_next = IDLE;
                end else if (sample_valid) begin
                    wr_en = 1'b1;
                    if (pre_cnt == ADDR_W'(PRE_TRIG - 1)) state_next = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (!arm) begin
                    state_next = IDLE;
                end else if (sample_valid) begin
                    wr_en     = 1'b1;
                    flag_set  = trig_slope ? (sample_in > thr_hi) : (sample_in < thr_lo);
                    level_hit = hyst_flag &&
                                (trig_slope ? (sample_in <= trig_level) : (sample_in >= trig_level));
                    auto_hit  = (tmo_cnt == TMO_W'(AUTO_TIMEOUT - 1));
                    if (level_hit || auto_hit) begin
                        trig_take  = 1'b1;
                        state_next = POST_FILL;
                    end
                end
            end
            POST_FILL: begin
                // arm is deliberately ignored here: a started frame always completes.
                if (post_cnt == '0) begin
                    done       = 1'b1;
                    state_next = HOLD;
                end else if (sample_valid) begin
                    wr_en = 1'b1;
                    if (post_cnt == ADDR_W'(1)) begin
                        done       = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_ack && frame_ready) begin
                    frame_release = 1'b1;
                    if (arm) begin
                        state_next = PRE_FILL;
                        clear_cnt  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            start_ptr   <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            tmo_cnt     <= '0;
            hyst_flag   <= 1'b0;
            frame_ready <= 1'b0;
            trig_auto   <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (clear_cnt) begin
                pre_cnt   <= '0;
                tmo_cnt   <= '0;
                hyst_flag <= 1'b0;
            end else begin
                if (state == PRE_FILL && wr_en) pre_cnt <= pre_cnt + 1'b1;
                if (state == WAIT_TRIG && wr_en) tmo_cnt <= tmo_cnt + 1'b1;
                if (flag_set) hyst_flag <= 1'b1;
            end
            if (trig_take) begin
                // Trigger sample lands at wr_ptr, so the frame starts PRE_TRIG entries back.
                start_ptr <= wr_ptr - ADDR_W'(PRE_TRIG);
                post_cnt  <= ADDR_W'(DEPTH - PRE_TRIG - 1);
                trig_auto <= !level_hit;
            end
            if (state == POST_FILL && wr_en) post_cnt <= post_cnt - 1'b1;
            if (done) frame_ready <= 1'b1;
            if (frame_release) begin
                frame_ready <= 1'b0;
                trig_auto   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_in;
    end

    // Read-first: a same-cycle write to rd_ptr is not visible until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[rd_ptr];
    end

endmodule
